cache_control: RTL
==================

// Module: cache_control
// PURPOSE
//  Sequencing FSM for the direct-mapped, write-back, write-allocate L1 cache datapath (8 sets x 256-bit lines).
//  Sits between the CPU mem_* handshake and the pmem_* handshake.
//  Drives the datapath strobes (tag/valid/dirty load, dirty_in, writing) from the datapath's hit/valid_out/dirty_out.
// PARAMETERS
//  CNT_W   32   width of each performance counter (used only with CACHE_PERF_CNT_EN)
// PORTS
//  clk          in   1      clock, all state changes on rising edge
//  rst_n        in   1      reset, asynchronous, active-low
//  mem_read     in   1      CPU read request, held until mem_resp
//  mem_write    in   1      CPU write request, held until mem_resp
//  mem_resp     out  1      one-cycle completion pulse to CPU
//  pmem_read    out  1      line fill request, held until pmem_resp
//  pmem_write   out  1      line writeback request, held until pmem_resp
//  pmem_resp    in   1      physical memory completion, one cycle
//  hit          in   1      datapath: valid && tag match for current index
//  valid_out    in   1      datapath: valid bit of current set
//  dirty_out    in   1      datapath: dirty bit of current set
//  tag_load     out  1      write tag array
//  valid_load   out  1      write valid array (data in = 1)
//  dirty_load   out  1      write dirty array
//  dirty_in     out  1      dirty bit value written when dirty_load=1
//  writing      out  2      00 fill from pmem_rdata, 01 CPU write (byte-masked), 10 hold
//  hit_count/miss_count/wb_count  out  CNT_W  perf counters (only with CACHE_PERF_CNT_EN)
// BEHAVIOUR
//  States: IDLE, CHECK, WRITEBACK, FILL. Strobe outputs are combinational from state+inputs.
//  Every output not named in a state is 0; writing defaults to 2'b10.
//  Reset (rst_n=0): state=IDLE immediately; all outputs 0, writing=2'b10, counters 0.
//  Reset mid-operation: pmem_read/pmem_write drop in the same cycle; no mem_resp is issued.
//  IDLE: if mem_read|mem_write -> CHECK. No strobes asserted.
//  CHECK, request present and hit=1 -> IDLE.
//   Read: mem_resp=1.
//   Write: writing=01, dirty_load=1, dirty_in=1, mem_resp=1.
//  CHECK, request present and hit=0:
//   valid_out & dirty_out -> WRITEBACK; otherwise -> FILL. No strobes asserted.
//  CHECK, request dropped (protocol violation): -> IDLE, no strobes.
//  WRITEBACK: pmem_write=1 every cycle.
//   Datapath drives victim address {tag_out,index} while dirty_out=1.
//   On pmem_resp: dirty_load=1, dirty_in=0; -> FILL.
//   Clearing dirty switches pmem_address to the request address.
//  FILL: pmem_read=1 every cycle.
//   On pmem_resp: writing=00, tag_load=1, valid_load=1, dirty_load=1, dirty_in=0; -> CHECK.
//   The re-check hits and completes the request.
//  Latency (edges from request seen in IDLE): hit -> mem_resp in cycle 2.
//  Clean miss: 2 + fill wait + 2. Dirty miss adds writeback wait + 1.
//  mem_read & mem_write both high: treated as write.
//  pmem_resp outside WRITEBACK/FILL: ignored.
//  mem_resp never asserts in two consecutive cycles.
//  pmem_read and pmem_write are never high together.
// CONFIGURATION
//  CACHE_PERF_CNT_EN defined: hit_count, miss_count, wb_count ports exist.
//   hit_count/miss_count incr on first CHECK of each request (hit / miss).
//   Re-check after fill is not counted.
//   wb_count incr on entry to WRITEBACK. All counters saturate at all-ones.
//  Undefined: ports and counter logic absent; FSM behaviour identical.
// TESTING
//  Reset: rst_n=0 mid-FILL -> pmem_read=0 same cycle, state IDLE, writing=10, mem_resp never pulses.
//  Cold read 0x0000_0040, valid_out=0, pmem_resp after 5 cycles
//   -> pmem_read held 5 cycles; one-cycle tag/valid/dirty_load (dirty_in=0, writing=00);
//   -> mem_resp 2 cycles later.
//  Read hit (hit=1) -> mem_resp at 2nd edge; no pmem_* activity; strobes all 0.
//  Write hit, mem_byte_enable=0x0000_000F -> one cycle: writing=01, dirty_load=1, dirty_in=1, mem_resp=1.
//  Dirty miss (valid_out=1, dirty_out=1, hit=0)
//   -> pmem_write until pmem_resp; dirty_load with dirty_in=0; pmem_read until pmem_resp; then mem_resp.
//  Both mem_read=mem_write=1 on hit -> writing=01 path. Stray pmem_resp in IDLE -> no state change.
//  With CACHE_PERF_CNT_EN: 3 hits, 2 misses (1 dirty) -> hit_count=3, miss_count=2, wb_count=1.

Source files
------------

// File: rtl/cache_control_if.sv
// CPU, physical-memory and datapath-strobe signals of the L1 cache controller.
// master = environment (CPU, pmem, datapath status); slave = the controller.
interface cache_control_if;
  logic       mem_read;
  logic       mem_write;
  logic       mem_resp;
  logic       pmem_read;
  logic       pmem_write;
  logic       pmem_resp;
  logic       hit;
  logic       valid_out;
  logic       dirty_out;
  logic       tag_load;
  logic       valid_load;
  logic       dirty_load;
  logic       dirty_in;
  logic [1:0] writing;

  modport master (
    output mem_read, mem_write, pmem_resp, hit, valid_out, dirty_out,
    input  mem_resp, pmem_read, pmem_write, tag_load, valid_load,
           dirty_load, dirty_in, writing
  );

  modport slave (
    input  mem_read, mem_write, pmem_resp, hit, valid_out, dirty_out,
    output mem_resp, pmem_read, pmem_write, tag_load, valid_load,
           dirty_load, dirty_in, writing
  );
endinterface

// File: rtl/cache_control.sv
// Sequencing FSM for a direct-mapped write-back/write-allocate L1 cache.
// Optional perf counters (hit/miss/writeback) exist only when CACHE_PERF_CNT_EN is defined.
module cache_control
`ifdef CACHE_PERF_CNT_EN
  #(parameter int CNT_W = 32)
`endif
(
  input  logic             clk,
  input  logic             rst_n,
  cache_control_if.slave   bus
`ifdef CACHE_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count,
  output logic [CNT_W-1:0] wb_count
`endif
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CHECK     = 2'd1,
    WRITEBACK = 2'd2,
    FILL      = 2'd3
  } state_t;

  localparam logic [1:0] WR_FILL = 2'b00;
  localparam logic [1:0] WR_CPU  = 2'b01;
  localparam logic [1:0] WR_HOLD = 2'b10;

  state_t state;
  logic   req;

  // A simultaneous read+write is handled as a write.
  assign req = bus.mem_read | bus.mem_write;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      unique case (state)
        IDLE:      if (req) state <= CHECK;
        CHECK: begin
          if (!req || bus.hit)                 state <= IDLE;
          else if (bus.valid_out && bus.dirty_out) state <= WRITEBACK;
          else                                  state <= FILL;
        end
        WRITEBACK: if (bus.pmem_resp) state <= FILL;
        FILL:      if (bus.pmem_resp) state <= CHECK;
        default:   state <= IDLE;
      endcase
    end
  end

  // Strobes are decoded from state so a reset drops pmem_* in the same cycle.
  always_comb begin
    bus.mem_resp   = 1'b0;
    bus.pmem_read  = 1'b0;
    bus.pmem_write = 1'b0;
    bus.tag_load   = 1'b0;
    bus.valid_load = 1'b0;
    bus.dirty_load = 1'b0;
    bus.dirty_in   = 1'b0;
    bus.writing    = WR_HOLD;
    unique case (state)
      CHECK: begin
        if (req && bus.hit) begin
          bus.mem_resp = 1'b1;
          if (bus.mem_write) begin
            bus.writing    = WR_CPU;
            bus.dirty_load = 1'b1;
            bus.dirty_in   = 1'b1;
          end
        end
      end
      WRITEBACK: begin
        bus.pmem_write = 1'b1;
        // Clearing dirty moves the datapath's pmem address off the victim line.
        if (bus.pmem_resp) bus.dirty_load = 1'b1;
      end
      FILL: begin
        bus.pmem_read = 1'b1;
        if (bus.pmem_resp) begin
          bus.writing    = WR_FILL;
          bus.tag_load   = 1'b1;
          bus.valid_load = 1'b1;
          bus.dirty_load = 1'b1;
        end
      end
      default: ;
    endcase
  end

`ifdef CACHE_PERF_CNT_EN
  // Marks the CHECK that follows a fill so the re-check is not counted.
  logic rechk;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rechk      <= 1'b0;
      hit_count  <= '0;
      miss_count <= '0;
      wb_count   <= '0;
    end else begin
      if (state == FILL && bus.pmem_resp) rechk <= 1'b1;
      else if (state == CHECK)            rechk <= 1'b0;

      if (state == CHECK && req && !rechk) begin
        if (bus.hit) begin
          if (hit_count != '1) hit_count <= hit_count + CNT_W'(1);
        end else begin
          if (miss_count != '1) miss_count <= miss_count + CNT_W'(1);
        end
      end

      if (state == CHECK && req && !bus.hit && bus.valid_out && bus.dirty_out &&
          wb_count != '1)
        wb_count <= wb_count + CNT_W'(1);
    end
  end
`endif

endmodule
